// File: rtl/iram_issue_sched.sv
// Issue scheduler for the 16-pack x 2-slot instruction RAM: in-order pack allocation,
// oldest-first dual issue to ALU0/ALU1 and in-order pack retirement; all outputs registered.
module iram_issue_sched #(
    parameter int  NPACK = 16,
    localparam int PW    = $clog2(NPACK),
    localparam int RW    = PW + 1
) (
    input  logic          cpu_clk_i,
    input  logic          cpu_rst_i,
    input  logic          pack_valid_i,
    output logic          pack_ready_o,
    output logic [PW-1:0] pack_id_o,
    input  logic          ins0_valid_i,
    input  logic          ins1_valid_i,
    input  logic          ins0_rdy_i,
    input  logic          ins1_rdy_i,
    input  logic          wake_valid_i,
    input  logic [RW-1:0] wake_rob_i,
    input  logic          cmpl0_valid_i,
    input  logic [RW-1:0] cmpl0_rob_i,
    input  logic          cmpl1_valid_i,
    input  logic [RW-1:0] cmpl1_rob_i,
    input  logic          alu0_stall_i,
    input  logic          alu1_stall_i,
    output logic          alu0_valid_o,
    output logic [RW-1:0] alu0_rob_o,
    output logic          alu1_valid_o,
    output logic [RW-1:0] alu1_rob_o,
    output logic          retire_valid_o,
    output logic [PW-1:0] retire_pack_o
);
    localparam int NS = 2 * NPACK;

    // Slot state is indexed directly by ROB index {pack, slot}.
    logic [NS-1:0] occ, rdy, iss, done;
    logic [PW-1:0] head, tail;
    logic [PW:0]   count;

    logic [NS-1:0] elig;
    logic [RW-1:0] age_v, scan_idx, pick0, pick1, iss1_rob;
    logic          have0, have1, iss0_go, iss1_go;
    logic          alloc, retire_ok;

    assign pack_ready_o = (count != (PW+1)'(NPACK));
    assign pack_id_o    = tail;
    assign alloc        = pack_valid_i && pack_ready_o;
    assign elig         = occ & rdy & ~iss & ~done;

    // Walk slots from oldest (head pack, slot 0) to youngest; wraps naturally in PW bits.
    always_comb begin
        have0    = 1'b0;
        have1    = 1'b0;
        pick0    = '0;
        pick1    = '0;
        age_v    = '0;
        scan_idx = '0;
        for (int a = 0; a < NS; a++) begin
            age_v    = RW'(a);
            scan_idx = {head + age_v[RW-1:1], age_v[0]};
            if (elig[scan_idx]) begin
                if (!have0) begin
                    have0 = 1'b1;
                    pick0 = scan_idx;
                end else if (!have1) begin
                    have1 = 1'b1;
                    pick1 = scan_idx;
                end
            end
        end
    end

    // A stalled ALU0 hands the oldest slot to ALU1.
    assign iss0_go  = !alu0_stall_i && have0;
    assign iss1_go  = !alu1_stall_i && (alu0_stall_i ? have0 : have1);
    assign iss1_rob = alu0_stall_i ? pick0 : pick1;

    assign retire_ok = (count != '0)
                    && !(occ[{head, 1'b0}] && !done[{head, 1'b0}])
                    && !(occ[{head, 1'b1}] && !done[{head, 1'b1}]);

    // Later assignments deliberately override earlier ones: allocation and retire win over
    // stray wake/completion bits targeting the same pack.
    always_ff @(posedge cpu_clk_i or posedge cpu_rst_i) begin
        if (cpu_rst_i) begin
            occ            <= '0;
            rdy            <= '0;
            iss            <= '0;
            done           <= '0;
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            alu0_valid_o   <= 1'b0;
            alu0_rob_o     <= '0;
            alu1_valid_o   <= 1'b0;
            alu1_rob_o     <= '0;
            retire_valid_o <= 1'b0;
            retire_pack_o  <= '0;
        end else begin
            if (wake_valid_i && occ[wake_rob_i] && !done[wake_rob_i])
                rdy[wake_rob_i] <= 1'b1;
            if (cmpl0_valid_i) done[cmpl0_rob_i] <= 1'b1;
            if (cmpl1_valid_i) done[cmpl1_rob_i] <= 1'b1;
            if (iss0_go) iss[pick0]    <= 1'b1;
            if (iss1_go) iss[iss1_rob] <= 1'b1;

            if (!alu0_stall_i) begin
                alu0_valid_o <= have0;
                if (have0) alu0_rob_o <= pick0;
            end
            if (!alu1_stall_i) begin
                alu1_valid_o <= iss1_go;
                if (iss1_go) alu1_rob_o <= iss1_rob;
            end

            if (alloc) begin
                occ[{tail, 1'b0}]  <= ins0_valid_i;
                occ[{tail, 1'b1}]  <= ins1_valid_i;
                rdy[{tail, 1'b0}]  <= ins0_rdy_i;
                rdy[{tail, 1'b1}]  <= ins1_rdy_i;
                iss[{tail, 1'b0}]  <= 1'b0;
                iss[{tail, 1'b1}]  <= 1'b0;
                done[{tail, 1'b0}] <= 1'b0;
                done[{tail, 1'b1}] <= 1'b0;
                tail               <= tail + 1'b1;
            end

            retire_valid_o <= retire_ok;
            if (retire_ok) begin
                retire_pack_o      <= head;
                occ[{head, 1'b0}]  <= 1'b0;
                occ[{head, 1'b1}]  <= 1'b0;
                rdy[{head, 1'b0}]  <= 1'b0;
                rdy[{head, 1'b1}]  <= 1'b0;
                iss[{head, 1'b0}]  <= 1'b0;
                iss[{head, 1'b1}]  <= 1'b0;
                done[{head, 1'b0}] <= 1'b0;
                done[{head, 1'b1}] <= 1'b0;
                head               <= head + 1'b1;
            end

            if (alloc && !retire_ok)
                count <= count + 1'b1;
            else if (!alloc && retire_ok)
                count <= count - 1'b1;
        end
    end
endmodule

// File: tb/tb_iram_issue_sched.sv
// Directed and randomized bench for iram_issue_sched against a per-slot reference model.
module tb_iram_issue_sched;
    logic       cpu_clk_i = 1'b0;
    logic       cpu_rst_i;
    logic       pack_valid_i, pack_ready_o;
    logic [3:0] pack_id_o;
    logic       ins0_valid_i, ins1_valid_i, ins0_rdy_i, ins1_rdy_i;
    logic       wake_valid_i;
    logic [4:0] wake_rob_i;
    logic       cmpl0_valid_i, cmpl1_valid_i;
    logic [4:0] cmpl0_rob_i, cmpl1_rob_i;
    logic       alu0_stall_i, alu1_stall_i;
    logic       alu0_valid_o, alu1_valid_o, retire_valid_o;
    logic [4:0] alu0_rob_o, alu1_rob_o;
    logic [3:0] retire_pack_o;

    iram_issue_sched #(.NPACK(16)) dut (
        .cpu_clk_i(cpu_clk_i), .cpu_rst_i(cpu_rst_i),
        .pack_valid_i(pack_valid_i), .pack_ready_o(pack_ready_o), .pack_id_o(pack_id_o),
        .ins0_valid_i(ins0_valid_i), .ins1_valid_i(ins1_valid_i),
        .ins0_rdy_i(ins0_rdy_i), .ins1_rdy_i(ins1_rdy_i),
        .wake_valid_i(wake_valid_i), .wake_rob_i(wake_rob_i),
        .cmpl0_valid_i(cmpl0_valid_i), .cmpl0_rob_i(cmpl0_rob_i),
        .cmpl1_valid_i(cmpl1_valid_i), .cmpl1_rob_i(cmpl1_rob_i),
        .alu0_stall_i(alu0_stall_i), .alu1_stall_i(alu1_stall_i),
        .alu0_valid_o(alu0_valid_o), .alu0_rob_o(alu0_rob_o),
        .alu1_valid_o(alu1_valid_o), .alu1_rob_o(alu1_rob_o),
        .retire_valid_o(retire_valid_o), .retire_pack_o(retire_pack_o)
    );

    always #5 cpu_clk_i = ~cpu_clk_i;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: per-ROB-index state plus a circular pack window.
    bit m_occ[32], m_rdy[32], m_iss[32], m_done[32];
    int m_head, m_tail, m_cnt;
    bit m_a0v, m_a1v, m_rv;
    int m_a0r, m_a1r, m_rp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_occ[i] = 0; m_rdy[i] = 0; m_iss[i] = 0; m_done[i] = 0;
        end
        m_head = 0; m_tail = 0; m_cnt = 0;
        m_a0v = 0; m_a1v = 0; m_rv = 0; m_a0r = 0; m_a1r = 0; m_rp = 0;
    endtask

    task automatic idle();
        pack_valid_i = 0; ins0_valid_i = 0; ins1_valid_i = 0; ins0_rdy_i = 0; ins1_rdy_i = 0;
        wake_valid_i = 0; wake_rob_i = 0;
        cmpl0_valid_i = 0; cmpl0_rob_i = 0; cmpl1_valid_i = 0; cmpl1_rob_i = 0;
    endtask

    task automatic alloc(input bit v0, input bit v1, input bit r0, input bit r1);
        pack_valid_i = 1; ins0_valid_i = v0; ins1_valid_i = v1; ins0_rdy_i = r0; ins1_rdy_i = r1;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ":alu0_valid"}, alu0_valid_o, m_a0v);
        if (m_a0v) chk({tag, ":alu0_rob"}, alu0_rob_o, m_a0r);
        chk({tag, ":alu1_valid"}, alu1_valid_o, m_a1v);
        if (m_a1v) chk({tag, ":alu1_rob"}, alu1_rob_o, m_a1r);
        chk({tag, ":retire_valid"}, retire_valid_o, m_rv);
        if (m_rv) chk({tag, ":retire_pack"}, retire_pack_o, m_rp);
    endtask

    // One clock: check combinational outputs, advance model across the edge, check registers.
    task automatic tick(input string tag);
        int  e0, e1, r, p, h;
        bit  ret, al;
        #1;
        chk({tag, ":pack_ready"}, pack_ready_o, m_cnt != 16);
        chk({tag, ":pack_id"}, pack_id_o, m_tail);
        e0 = -1; e1 = -1;
        for (int age = 0; age < 32; age++) begin
            r = ((m_head + age / 2) % 16) * 2 + age % 2;
            if (m_occ[r] && m_rdy[r] && !m_iss[r] && !m_done[r]) begin
                if (e0 < 0) e0 = r;
                else if (e1 < 0) e1 = r;
            end
        end
        h = m_head;
        ret = (m_cnt > 0);
        for (int s = 0; s < 2; s++)
            if (m_occ[h * 2 + s] && !m_done[h * 2 + s]) ret = 0;
        al = pack_valid_i && (m_cnt != 16);
        @(posedge cpu_clk_i);
        if (wake_valid_i && m_occ[wake_rob_i] && !m_done[wake_rob_i]) m_rdy[wake_rob_i] = 1;
        if (cmpl0_valid_i) m_done[cmpl0_rob_i] = 1;
        if (cmpl1_valid_i) m_done[cmpl1_rob_i] = 1;
        if (!alu0_stall_i) begin
            m_a0v = (e0 >= 0);
            if (e0 >= 0) begin m_a0r = e0; m_iss[e0] = 1; end
        end
        if (!alu1_stall_i) begin
            p = alu0_stall_i ? e0 : e1;
            m_a1v = (p >= 0);
            if (p >= 0) begin m_a1r = p; m_iss[p] = 1; end
        end
        if (al) begin
            m_occ[m_tail * 2] = ins0_valid_i; m_occ[m_tail * 2 + 1] = ins1_valid_i;
            m_rdy[m_tail * 2] = ins0_rdy_i;   m_rdy[m_tail * 2 + 1] = ins1_rdy_i;
            m_iss[m_tail * 2] = 0;  m_iss[m_tail * 2 + 1] = 0;
            m_done[m_tail * 2] = 0; m_done[m_tail * 2 + 1] = 0;
            m_tail = (m_tail + 1) % 16;
            m_cnt++;
        end
        m_rv = ret;
        if (ret) begin
            m_rp = h;
            for (int s = 0; s < 2; s++) begin
                m_occ[h * 2 + s] = 0; m_rdy[h * 2 + s] = 0;
                m_iss[h * 2 + s] = 0; m_done[h * 2 + s] = 0;
            end
            m_head = (m_head + 1) % 16;
            m_cnt--;
        end
        #1;
        check_outs(tag);
    endtask

    task automatic do_reset();
        idle();
        alu0_stall_i = 0; alu1_stall_i = 0;
        cpu_rst_i = 1;
        #1;
        model_reset();
        check_outs("reset");
        chk("reset:pack_ready", pack_ready_o, 1);
        chk("reset:pack_id", pack_id_o, 0);
        @(posedge cpu_clk_i);
        #2;
        cpu_rst_i = 0;
        @(posedge cpu_clk_i);
        #1;
    endtask

    function automatic int find_inflight();
        int st = $urandom_range(0, 31);
        for (int k = 0; k < 32; k++)
            if (m_iss[(st + k) % 32] && !m_done[(st + k) % 32]) return (st + k) % 32;
        return -1;
    endfunction

    initial begin
        int c;
        idle();
        alu0_stall_i = 0; alu1_stall_i = 0;

        // In-order dual issue of three fully ready packs.
        do_reset();
        alloc(1, 1, 1, 1); tick("seq_a0");
        tick("seq_a1");
        chk("seq:c1_alu0", alu0_rob_o, 0); chk("seq:c1_alu1", alu1_rob_o, 1);
        tick("seq_a2");
        chk("seq:c2_alu0", alu0_rob_o, 2); chk("seq:c2_alu1", alu1_rob_o, 3);
        idle(); tick("seq_i");
        chk("seq:c3_alu0", alu0_rob_o, 4); chk("seq:c3_alu1", alu1_rob_o, 5);

        // Wakeup latency.
        do_reset();
        alloc(1, 1, 0, 0); tick("wk_alloc");
        idle(); tick("wk_idle");
        chk("wk:no_issue", alu0_valid_o, 0);
        wake_valid_i = 1; wake_rob_i = 1; tick("wk_w1");
        idle(); tick("wk_i1");
        chk("wk:rob1", alu0_rob_o, 1); chk("wk:alu1_idle", alu1_valid_o, 0);
        wake_valid_i = 1; wake_rob_i = 0; tick("wk_w0");
        idle(); tick("wk_i0");
        chk("wk:rob0", alu0_rob_o, 0); chk("wk:rob0_v", alu0_valid_o, 1);

        // ALU0 stalled: ALU1 takes the oldest.
        do_reset();
        alu0_stall_i = 1;
        alloc(1, 1, 1, 1); tick("st_alloc");
        idle(); tick("st_i0");
        chk("st:alu1_first", alu1_rob_o, 0); chk("st:alu0_hold", alu0_valid_o, 0);
        tick("st_i1");
        chk("st:alu1_second", alu1_rob_o, 1); chk("st:alu0_hold2", alu0_valid_o, 0);
        alu0_stall_i = 0;

        // Fill to 16 packs, blocked 17th, retire reopens the window.
        do_reset();
        for (int i = 0; i < 16; i++) begin alloc(1, 1, 0, 0); tick("full_alloc"); end
        chk("full:ready_low", pack_ready_o, 0);
        tick("full_17th");
        idle();
        cmpl0_valid_i = 1; cmpl0_rob_i = 0; cmpl1_valid_i = 1; cmpl1_rob_i = 1;
        tick("full_cmpl");
        idle(); tick("full_ret");
        chk("full:retire_v", retire_valid_o, 1); chk("full:retire_p", retire_pack_o, 0);
        chk("full:ready_back", pack_ready_o, 1); chk("full:next_id", pack_id_o, 0);
        alloc(1, 1, 0, 0); tick("full_realloc");
        idle();

        // Wrap-around age ordering with head=14, tail=2.
        do_reset();
        for (int i = 0; i < 14; i++) begin alloc(0, 0, 0, 0); tick("wr_empty"); end
        idle();
        for (int i = 0; i < 3; i++) tick("wr_drain");
        alu0_stall_i = 1; alu1_stall_i = 1;
        for (int i = 0; i < 4; i++) begin alloc(1, 1, 1, 1); tick("wr_alloc"); end
        idle();
        alu0_stall_i = 0; alu1_stall_i = 0;
        tick("wr_0"); chk("wr:28", alu0_rob_o, 28); chk("wr:29", alu1_rob_o, 29);
        tick("wr_1"); chk("wr:30", alu0_rob_o, 30); chk("wr:31", alu1_rob_o, 31);
        tick("wr_2"); chk("wr:0", alu0_rob_o, 0);   chk("wr:1", alu1_rob_o, 1);
        tick("wr_3"); chk("wr:2", alu0_rob_o, 2);   chk("wr:3", alu1_rob_o, 3);

        // In-order retire: younger pack done first must wait.
        do_reset();
        alloc(1, 1, 0, 0); tick("rt_a0");
        alloc(1, 1, 0, 0); tick("rt_a1");
        idle();
        cmpl0_valid_i = 1; cmpl0_rob_i = 2; cmpl1_valid_i = 1; cmpl1_rob_i = 3; tick("rt_c1");
        idle(); tick("rt_wait");
        chk("rt:no_retire", retire_valid_o, 0);
        cmpl0_valid_i = 1; cmpl0_rob_i = 0; cmpl1_valid_i = 1; cmpl1_rob_i = 1; tick("rt_c0");
        idle(); tick("rt_r0");
        chk("rt:r0_v", retire_valid_o, 1); chk("rt:r0_p", retire_pack_o, 0);
        tick("rt_r1");
        chk("rt:r1_v", retire_valid_o, 1); chk("rt:r1_p", retire_pack_o, 1);

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            idle();
            if ($urandom_range(0, 2) != 0) alloc($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                                               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) begin
                wake_valid_i = 1; wake_rob_i = 5'($urandom_range(0, 31));
            end
            c = find_inflight();
            if (c >= 0 && $urandom_range(0, 1) == 1) begin cmpl0_valid_i = 1; cmpl0_rob_i = 5'(c); end
            c = find_inflight();
            if (c >= 0 && $urandom_range(0, 1) == 1) begin cmpl1_valid_i = 1; cmpl1_rob_i = 5'(c); end
            alu0_stall_i = ($urandom_range(0, 3) == 0);
            alu1_stall_i = ($urandom_range(0, 3) == 0);
            tick("rand");
        end

        // Reset mid-stream clears outputs without waiting for a clock.
        cpu_rst_i = 1;
        #1;
        chk("mid_rst:alu0_valid", alu0_valid_o, 0);
        chk("mid_rst:alu1_valid", alu1_valid_o, 0);
        chk("mid_rst:retire_valid", retire_valid_o, 0);
        chk("mid_rst:alu0_rob", alu0_rob_o, 0);
        chk("mid_rst:alu1_rob", alu1_rob_o, 0);
        chk("mid_rst:retire_pack", retire_pack_o, 0);
        chk("mid_rst:pack_id", pack_id_o, 0);
        chk("mid_rst:pack_ready", pack_ready_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
